// File: rtl/legv8_div_controller.sv
// legv8_div_controller
// Multicycle restoring divider sequencer for LEGv8 UDIV/SDIV.
// Operands are captured as magnitudes, divided at one quotient bit per cycle,
// then sign-corrected and presented together with a one-cycle done pulse.
// A zero divisor bypasses the iterations and reports div_by_zero instead.

module legv8_div_controller #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    // The shift/compare step and the counter both need at least a few bits.
    generate
        if (WIDTH < 4) begin : g_width_check
            $error("legv8_div_controller: WIDTH must be >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    // q_reg starts as |dividend| and is shifted out into the partial remainder
    // while quotient bits are shifted in from the right.
    logic [WIDTH-1:0] q_reg, q_next;
    // Partial remainder is always < |divisor| between steps, so WIDTH bits
    // suffice to store it; the WIDTH+1 bit version only exists during compare.
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] dsr_reg, dsr_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;
    logic             done_reg, done_next;

    logic [WIDTH:0]   shifted;
    logic             fits;

    // Two's-complement magnitude; MIN stays MIN, which is its correct
    // unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    // State register and all datapath registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            q_reg         <= '0;
            rem_reg       <= '0;
            dsr_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            q_reg         <= q_next;
            rem_reg       <= rem_next;
            dsr_reg       <= dsr_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
            done_reg      <= done_next;
        end
    end

    // Next-state, iteration step and result formation.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        q_next         = q_reg;
        rem_next       = rem_reg;
        dsr_next       = dsr_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        done_next      = 1'b0;

        shifted = {rem_reg, q_reg[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr_reg});

        case (state_reg)
            IDLE: begin
                if (start) begin
                    q_next     = magnitude(dividend, is_signed);
                    dsr_next   = magnitude(divisor, is_signed);
                    rem_next   = '0;
                    neg_r_next = is_signed & dividend[WIDTH-1];
                    neg_q_next = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    count_next = CW'(WIDTH - 1);
                    dbz_next   = 1'b0;
                    state_next = (divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                // Result of the subtraction is below |divisor|, so the low
                // WIDTH bits of the modular difference are exact.
                rem_next = fits ? (shifted[WIDTH-1:0] - dsr_reg) : shifted[WIDTH-1:0];
                q_next   = {q_reg[WIDTH-2:0], fits};
                count_next = count_reg - CW'(1);
                if (count_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                quotient_next  = neg_q_reg ? -q_reg : q_reg;
                remainder_next = neg_r_reg ? -rem_reg : rem_reg;
                done_next      = 1'b1;
                state_next     = IDLE;
            end
            ZERO: begin
                // Re-applying the sign to the stored magnitude restores the
                // dividend bit-for-bit.
                quotient_next  = '0;
                remainder_next = neg_r_reg ? -q_reg : q_reg;
                dbz_next       = 1'b1;
                done_next      = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy drops in the done cycle so the issue logic can start back-to-back.
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule
